// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
// Holds the loader state enum, memory geometry and the length-field mask.
package imem_loader_pkg;

    localparam int ADDR_W          = 12;
    localparam int INSTR_W         = 19;
    localparam int BYTES_PER_INSTR = 3;

    localparam logic [ADDR_W-1:0] LEN_MASK = 12'hFFF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE,
        S_CHK,
        S_DONE
    } loader_state_t;

endpackage

// File: rtl/imem_loader_assembler.sv
// Instruction word assembler: shifts stream bytes big-endian into a word
// and exposes the INSTR_W-bit instruction slice.
// Ports: clk, rst (async active-low), clr (zero word/checksum),
//   shift_en (accept byte_in), byte_in, instr (assembled word),
//   csum (XOR of shifted bytes, only with IMEM_LOADER_CHECKSUM_EN).
module imem_loader_assembler
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift_en,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] instr
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]         csum
`endif
);

    // Only the low INSTR_W bits of the BYTES_PER_INSTR*8-bit word are kept;
    // the upper bits would be discarded on write anyway, so they simply
    // fall off the top of the shift.
    logic [INSTR_W-1:0] asm_q;
    logic [INSTR_W-1:0] asm_d;

    always_comb begin
        asm_d = asm_q;
        if (clr) begin
            asm_d = '0;
        end else if (shift_en) begin
            asm_d = INSTR_W'({asm_q, byte_in});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_q <= '0;
        end else begin
            asm_q <= asm_d;
        end
    end

    assign instr = asm_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;
    logic [7:0] csum_d;

    always_comb begin
        csum_d = csum_q;
        if (clr) begin
            csum_d = '0;
        end else if (shift_en) begin
            csum_d = csum_q ^ byte_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`endif

endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a byte stream (2 length bytes,
// then 3 big-endian bytes per instruction) and holds the CPU until done.
// Ports: clk, rst (async active-low), start, byte_in/byte_valid/byte_ready,
//   imem_we/imem_addr/imem_wdata, cpu_hold, done, err.
// Option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t S_LAST = S_CHK;
`else
    localparam loader_state_t S_LAST = S_DONE;
`endif

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] len_lo_cand;
    logic              asm_clr;
    logic              asm_shift;
    logic [INSTR_W-1:0] asm_instr;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic       err_q, err_d;
    logic [7:0] csum;
`endif

    assign addr_nxt    = addr_q + 1'b1;
    assign len_lo_cand = LEN_MASK & {len_q[11:8], byte_in};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        asm_clr    = 1'b0;
        asm_shift  = 1'b0;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    addr_d  = '0;
                    asm_clr = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    len_d   = {byte_in[3:0], len_q[7:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    len_d   = len_lo_cand;
                    state_d = (len_lo_cand == '0) ? S_LAST : S_B0;
                end
            end
            S_B0, S_B1, S_B2: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    asm_shift = 1'b1;
                    unique case (1'b1)
                        state_q == S_B0: state_d = S_B1;
                        state_q == S_B1: state_d = S_B2;
                        default:         state_d = S_WRITE;
                    endcase
                end
            end
            S_WRITE: begin
                imem_we = 1'b1;
                addr_d  = addr_nxt;
                state_d = (addr_nxt < len_q) ? S_B0 : S_LAST;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    err_d   = (byte_in != csum);
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    imem_loader_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (asm_clr),
        .shift_en (asm_shift),
        .byte_in  (byte_in),
        .instr    (asm_instr)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .csum     (csum)
`endif
    );

    assign imem_addr  = addr_q;
    assign imem_wdata = asm_instr;
    assign cpu_hold   = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: stream parser model pushes
// expected writes, a monitor pops and compares on every imem_we pulse.
module tb_imem_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [18:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;

    logic [11:0] exp_addr[$];
    logic [18:0] exp_data[$];
    logic        prev_we = 1'b0;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: every write pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (imem_we) begin
            check("we_single_cycle", {31'd0, prev_we}, 32'd0);
            if (exp_addr.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         imem_addr, imem_wdata);
            end else begin
                check("write_addr", {20'd0, imem_addr}, {20'd0, exp_addr.pop_front()});
                check("write_data", {13'd0, imem_wdata}, {13'd0, exp_data.pop_front()});
            end
        end
        prev_we = imem_we;
    end

    // Reference model: parse the stream as the format defines it.
    task automatic push_model(input bq_t s, output logic exp_err, output int n);
        logic [7:0]  x;
        logic [23:0] word;
        logic [11:0] a;
        n = int'({s[0][3:0], s[1]});
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            word = {s[2+3*i], s[3+3*i], s[4+3*i]};
            x    = x ^ s[2+3*i] ^ s[3+3*i] ^ s[4+3*i];
            a    = i[11:0];
            exp_addr.push_back(a);
            exp_data.push_back(word[18:0]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_err = (s[2+3*n] != x);
`else
        exp_err = 1'b0;
`endif
    endtask

    function automatic bq_t mk_stream(input int n, input logic bad_csum);
        bq_t         s;
        logic [11:0] nn;
        logic [7:0]  b;
        logic [7:0]  x;
        nn = n[11:0];
        x  = 8'h00;
        s.push_back({4'($urandom), nn[11:8]});
        s.push_back(nn[7:0]);
        for (int i = 0; i < 3*n; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            s.push_back(b);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(bad_csum ? (x ^ 8'h01) : x);
`else
        if (bad_csum) x = 8'h00;
`endif
        return s;
    endfunction

    // vmode: 0 valid held high, 1 toggling, 2 random with stray starts.
    // stop_at >= 0 stops feeding after that many transfers (no checks).
    task automatic run_load(input bq_t s, input int vmode, input int stop_at);
        int   n;
        int   cyc;
        int   idx;
        int   budget;
        int   exp_cyc;
        logic eerr;
        logic tog;
        logic xfer;
        n    = 0;
        eerr = 1'b0;
        if (stop_at < 0) push_model(s, eerr, n);
        budget = 20 * s.size() + 50;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        idx   = 0;
        tog   = 1'b1;
        while (1) begin
            @(negedge clk);
            if (stop_at >= 0 && idx == stop_at) break;
            if (stop_at < 0 && done && idx >= s.size()) break;
            if (cyc >= budget) begin
                fail_now("load_timeout");
                break;
            end
            start = (vmode == 2) && ($urandom_range(7) == 0);
            if (idx < s.size()) begin
                byte_in = s[idx];
                case (vmode)
                    0:       byte_valid = 1'b1;
                    1: begin
                        byte_valid = tog;
                        tog = !tog;
                    end
                    default: byte_valid = 1'($urandom_range(1));
                endcase
            end else begin
                byte_in    = 8'($urandom);
                byte_valid = 1'($urandom_range(1));
            end
            #1;
            xfer = byte_valid && byte_ready;
            @(posedge clk);
            cyc++;
            if (xfer) idx++;
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        if (stop_at < 0) begin
            check("bytes_consumed", idx, s.size());
            check("done", {31'd0, done}, 32'd1);
            check("cpu_hold_done", {31'd0, cpu_hold}, 32'd0);
            check("err", {31'd0, err}, {31'd0, eerr});
            check("ready_in_done", {31'd0, byte_ready}, 32'd0);
            check("final_addr", {20'd0, imem_addr}, n);
            check("writes_pending", exp_addr.size(), 0);
            if (vmode == 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                exp_cyc = 3 + 4*n;
`else
                exp_cyc = 2 + 4*n;
`endif
                check("load_cycles", cyc, exp_cyc);
            end
        end
    endtask

    initial begin
        bq_t s;
        rst        = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", {20'd0, imem_addr}, 32'd0);
        check("rst_wdata", {13'd0, imem_wdata}, 32'd0);
        check("rst_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b1;

        // Idle with bytes offered: nothing accepted, CPU still held.
        byte_valid = 1'b1;
        byte_in    = 8'hA5;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("idle_ready", {31'd0, byte_ready}, 32'd0);
        check("idle_hold", {31'd0, cpu_hold}, 32'd1);
        check("idle_done", {31'd0, done}, 32'd0);
        byte_valid = 1'b0;

        // Two-instruction directed load, held-high then toggling valid.
        s = {8'h00, 8'h02, 8'h07, 8'hFF, 8'hFF, 8'h01, 8'h23, 8'h45};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h60);
`endif
        run_load(s, 0, -1);
        run_load(s, 1, -1);

        // Zero-length load; upper nibble of the high length byte ignored.
        s = {8'hF0, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        run_load(s, 0, -1);

        // Reset after the second instruction byte of a 3-instruction load.
        s = mk_stream(3, 1'b0);
        run_load(s, 0, 4);
        #2;
        rst = 1'b0;
        #1;
        check("abort_ready", {31'd0, byte_ready}, 32'd0);
        check("abort_hold", {31'd0, cpu_hold}, 32'd1);
        check("abort_we", {31'd0, imem_we}, 32'd0);
        check("abort_addr", {20'd0, imem_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        s = mk_stream(3, 1'b0);
        run_load(s, 0, -1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        s = {8'h00, 8'h01, 8'h01, 8'h23, 8'h45, 8'h67};
        run_load(s, 0, -1);
        s = {8'h00, 8'h01, 8'h01, 8'h23, 8'h45, 8'h66};
        run_load(s, 0, -1);
        s = mk_stream(4, 1'b1);
        run_load(s, 2, -1);
`endif

        // Randomized loads with random valid gaps and stray start pulses.
        for (int t = 0; t < 10; t++) begin
            s = mk_stream(int'($urandom_range(1, 20)), 1'($urandom_range(1)));
            run_load(s, 2, -1);
        end

        // Maximum length: last write at 4094, address ends at 4095.
        s = mk_stream(4095, 1'b0);
        run_load(s, 0, -1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
